bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 13 +
 rtl/bus_arbiter.sv | 67 ++++++
 tb/tb_bus_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/handshake inputs and grant outputs between the masters and the arbiter
interface bus_arbiter_if #(parameter int NUM_MASTERS = 16);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] grant;
  logic [IW-1:0] grant_id;
  logic a_fire;
  logic d_fire;
  logic busy;
  logic timeout;
  modport master(output request, a_fire, d_fire, input grant, grant_id, busy, timeout);
  modport slave(input request, a_fire, d_fire, output grant, grant_id, busy, timeout);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter holding one grant per address/response transaction with a timeout
module bus_arbiter #(
  parameter int NUM_MASTERS = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  bus_arbiter_if.slave bus
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  state_t state, state_n;
  logic [NUM_MASTERS-1:0] grant;
  logic [IW-1:0] grant_id, last_id, win, idx;
  logic [CW-1:0] cnt;
  logic found, expire, tmo;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = IW'((int'(last_id) + i) % NUM_MASTERS);
      if (!found && bus.request[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign expire = cnt == CW'(TIMEOUT_CYCLES - 1);
  // a timeout only fires when nothing else would already end the transaction
  always_comb begin
    state_n = state;
    tmo = 1'b0;
    case (state)
      IDLE: state_n = found ? ADDR : IDLE;
      ADDR: state_n = bus.a_fire ? (bus.d_fire ? IDLE : RESP) : (bus.request[grant_id] ? ADDR : IDLE);
      RESP: state_n = bus.d_fire ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && state_n != IDLE && expire) begin
      tmo = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      last_id <= IW'(NUM_MASTERS - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || state_n == IDLE || (state == ADDR && bus.a_fire)) ? '0 : cnt + 1'b1;
      grant <= state_n == IDLE ? '0 : (state == IDLE ? NUM_MASTERS'(1) << win : grant);
      if (state == IDLE && found) begin
        grant_id <= win;
        last_id <= win;
      end
    end
  end
  assign bus.grant = grant;
  assign bus.grant_id = grant_id;
  assign bus.busy = state != IDLE;
  assign bus.timeout = tmo;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenario tests for bus_arbiter with hand-computed expectations
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  bus_arbiter_if #(.NUM_MASTERS(16)) bus();
  bus_arbiter #(.NUM_MASTERS(16), .TIMEOUT_CYCLES(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.request = '0;
    bus.a_fire = 1'b0;
    bus.d_fire = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.request = 16'h0003;
    bus.a_fire = 1'b0;
    bus.d_fire = 1'b0;
    cyc();
    vectors++; if (bus.grant !== 16'h0000) begin errors++; $display("FAIL reset_grant: got %h want %h", bus.grant, 16'h0000); end
    vectors++; if (bus.grant_id !== 4'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    cyc();
    vectors++; if (bus.grant !== 16'h0001) begin errors++; $display("FAIL basic_grant0: got %h want %h", bus.grant, 16'h0001); end
    vectors++; if (bus.grant_id !== 4'd0) begin errors++; $display("FAIL basic_id0: got %0d want 0", bus.grant_id); end
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    bus.a_fire = 1'b1;
    cyc();
    vectors++; if (bus.grant !== 16'h0001) begin errors++; $display("FAIL basic_resp_hold: got %h want %h", bus.grant, 16'h0001); end
    bus.a_fire = 1'b0;
    bus.d_fire = 1'b1;
    #1;
    vectors++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL basic_no_timeout: got %b want 0", bus.timeout); end
    cyc();
    vectors++; if (bus.grant !== 16'h0000) begin errors++; $display("FAIL basic_idle_gap: got %h want %h", bus.grant, 16'h0000); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
    bus.d_fire = 1'b0;
    cyc();
    vectors++; if (bus.grant !== 16'h0002) begin errors++; $display("FAIL basic_grant1: got %h want %h", bus.grant, 16'h0002); end
    vectors++; if (bus.grant_id !== 4'd1) begin errors++; $display("FAIL basic_id1: got %0d want 1", bus.grant_id); end
  endtask

  task automatic test_single_cycle;
    bus.a_fire = 1'b1;
    bus.d_fire = 1'b1;
    bus.request = '0;
    cyc();
    vectors++; if (bus.grant !== 16'h0000) begin errors++; $display("FAIL single_grant: got %h want %h", bus.grant, 16'h0000); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", bus.timeout); end
    cyc();
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_fire_ignored: got %b want 0", bus.busy); end
    bus.a_fire = 1'b0;
    bus.d_fire = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [15:0] exp_g [3];
    logic [3:0] exp_id [3];
    exp_g = '{16'h0001, 16'h8000, 16'h0001};
    exp_id = '{4'd0, 4'd15, 4'd0};
    do_reset();
    bus.request = 16'h8001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++; if (bus.grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %h want %h", i, bus.grant, exp_g[i]); end
      vectors++; if (bus.grant_id !== exp_id[i]) begin errors++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, bus.grant_id, exp_id[i]); end
      bus.a_fire = 1'b1;
      bus.d_fire = 1'b1;
      cyc();
      vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got %b want 0", i, bus.busy); end
      bus.a_fire = 1'b0;
      bus.d_fire = 1'b0;
    end
    bus.request = '0;
    cyc();
  endtask

  task automatic test_timeout_resp;
    bus.request = 16'h0004;
    cyc();
    vectors++; if (bus.grant !== 16'h0004) begin errors++; $display("FAIL tr_grant: got %h want %h", bus.grant, 16'h0004); end
    bus.a_fire = 1'b1;
    cyc();
    bus.a_fire = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) begin
      vectors++; if (bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL tr_early[%0d]: got timeout=%b busy=%b want 0/1", i, bus.timeout, bus.busy); end
      cyc();
    end
    vectors++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL tr_pulse: got %b want 1", bus.timeout); end
    vectors++; if (bus.grant !== 16'h0004) begin errors++; $display("FAIL tr_pulse_grant: got %h want %h", bus.grant, 16'h0004); end
    bus.request = '0;
    cyc();
    vectors++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL tr_pulse_end: got %b want 0", bus.timeout); end
    vectors++; if (bus.grant !== 16'h0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL tr_revoked: got grant=%h busy=%b want 0000/0", bus.grant, bus.busy); end
  endtask

  task automatic test_timeout_addr;
    bus.request = 16'h0008;
    cyc();
    vectors++; if (bus.grant !== 16'h0008) begin errors++; $display("FAIL ta_grant: got %h want %h", bus.grant, 16'h0008); end
    for (int i = 0; i < 7; i++) begin
      vectors++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL ta_early[%0d]: got %b want 0", i, bus.timeout); end
      cyc();
    end
    vectors++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL ta_pulse: got %b want 1", bus.timeout); end
    cyc();
    bus.request = '0;
    vectors++; if (bus.timeout !== 1'b0 || bus.grant !== 16'h0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL ta_revoked: got timeout=%b grant=%h busy=%b want 0/0000/0", bus.timeout, bus.grant, bus.busy); end
  endtask

  task automatic test_completion_precedence;
    bus.request = 16'h0010;
    cyc();
    vectors++; if (bus.grant !== 16'h0010) begin errors++; $display("FAIL cp_grant: got %h want %h", bus.grant, 16'h0010); end
    bus.a_fire = 1'b1;
    cyc();
    bus.a_fire = 1'b0;
    repeat (7) cyc();
    bus.d_fire = 1'b1;
    #1;
    vectors++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL cp_no_pulse: got %b want 0", bus.timeout); end
    bus.request = '0;
    cyc();
    bus.d_fire = 1'b0;
    vectors++; if (bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL cp_idle: got busy=%b timeout=%b want 0/0", bus.busy, bus.timeout); end
  endtask

  task automatic test_withdraw;
    do_reset();
    bus.request = 16'h0004;
    cyc();
    vectors++; if (bus.grant !== 16'h0004) begin errors++; $display("FAIL wd_grant: got %h want %h", bus.grant, 16'h0004); end
    bus.request = '0;
    cyc();
    vectors++; if (bus.grant !== 16'h0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL wd_idle: got grant=%h busy=%b want 0000/0", bus.grant, bus.busy); end
    bus.request = 16'h0005;
    cyc();
    vectors++; if (bus.grant !== 16'h0001) begin errors++; $display("FAIL wd_next: got %h want %h", bus.grant, 16'h0001); end
    vectors++; if (bus.grant_id !== 4'd0) begin errors++; $display("FAIL wd_next_id: got %0d want 0", bus.grant_id); end
  endtask

  task automatic test_reset_mid;
    bus.a_fire = 1'b1;
    bus.request = '0;
    cyc();
    bus.a_fire = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_in_resp: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.grant !== 16'h0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL rm_async: got grant=%h busy=%b timeout=%b want 0000/0/0", bus.grant, bus.busy, bus.timeout); end
    cyc();
    rst = 1'b0;
    bus.request = 16'h0010;
    cyc();
    vectors++; if (bus.grant !== 16'h0010) begin errors++; $display("FAIL rm_resume: got %h want %h", bus.grant, 16'h0010); end
    vectors++; if (bus.grant_id !== 4'd4) begin errors++; $display("FAIL rm_resume_id: got %0d want 4", bus.grant_id); end
  endtask

  initial begin
    bus.request = '0;
    bus.a_fire = 1'b0;
    bus.d_fire = 1'b0;
    test_reset();
    test_basic();
    test_single_cycle();
    test_round_robin();
    test_timeout_resp();
    test_timeout_addr();
    test_completion_precedence();
    test_withdraw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
